// File: rtl/d_bus_xbar_if.sv
// Bundle of core-side and slave-side signals of the data bus router.
// The router takes the slave modport; the core/slave models take master.
interface d_bus_xbar_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 16,
  parameter int NUM_SLV  = 2
);
  logic [ADDR_LEN-1:0]     addr;
  logic                    rd_req;
  logic                    wr_req;
  logic [XLEN/8-1:0]       be;
  logic [XLEN-1:0]         wr_data;
  logic                    rd_ready;
  logic                    wr_ready;
  logic [XLEN-1:0]         rd_data;
  logic                    bus_err;
  logic [7:0]              err_cnt;
  logic [ADDR_LEN-1:0]     s_addr;
  logic [NUM_SLV-1:0]      s_rd_req;
  logic [NUM_SLV-1:0]      s_wr_req;
  logic [XLEN/8-1:0]       s_be;
  logic [XLEN-1:0]         s_wr_data;
  logic [NUM_SLV*XLEN-1:0] s_rd_data;
  logic [NUM_SLV-1:0]      s_rd_ready;
  logic [NUM_SLV-1:0]      s_wr_ready;

  modport slave (
    input  addr, rd_req, wr_req, be, wr_data, s_rd_data, s_rd_ready, s_wr_ready,
    output rd_ready, wr_ready, rd_data, bus_err, err_cnt,
           s_addr, s_rd_req, s_wr_req, s_be, s_wr_data
  );

  modport master (
    output addr, rd_req, wr_req, be, wr_data, s_rd_data, s_rd_ready, s_wr_ready,
    input  rd_ready, wr_ready, rd_data, bus_err, err_cnt,
           s_addr, s_rd_req, s_wr_req, s_be, s_wr_data
  );
endinterface

// File: rtl/d_bus_xbar.sv
// Data-side router: decodes the core address onto one of NUM_SLV slaves, holds a
// registered request until the slave answers or times out, then pulses ready back.
module d_bus_xbar #(
  parameter int                          XLEN     = 32,
  parameter int                          ADDR_LEN = 16,
  parameter int                          NUM_SLV  = 2,
  parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_BASE = {16'h8000, 16'h0000},
  parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_MASK = {16'h8000, 16'hF000},
  parameter int                          TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rstb,
  d_bus_xbar_if.slave   bus
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                dir_q, dir_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [ADDR_LEN-1:0] s_addr_q, s_addr_d;
  logic [BW-1:0]       s_be_q, s_be_d;
  logic [XLEN-1:0]     s_wdata_q, s_wdata_d;
  logic [NUM_SLV-1:0]  s_rd_req_q, s_rd_req_d;
  logic [NUM_SLV-1:0]  s_wr_req_q, s_wr_req_d;
  logic                rd_ready_q, rd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic                bus_err_q, bus_err_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                req;
  logic                hit;
  logic [SW-1:0]       hit_idx;
  logic [NUM_SLV-1:0]  hit_oh;
  logic                done;
  logic                tmo;
  logic [XLEN-1:0]     sel_rdata;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Scan downward so the lowest matching window is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((bus.addr & SLV_MASK[i*ADDR_LEN +: ADDR_LEN]) == SLV_BASE[i*ADDR_LEN +: ADDR_LEN]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign req       = bus.rd_req | bus.wr_req;
  assign hit_oh    = NUM_SLV'(1) << hit_idx;
  assign sel_rdata = bus.s_rd_data[int'(sel_q)*XLEN +: XLEN];
  assign done      = dir_q ? bus.s_wr_ready[sel_q] : bus.s_rd_ready[sel_q];
  assign tmo       = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = hit ? BUSY : RESP;
      BUSY:    if (done || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready/error are set only on the transition into RESP, so they last exactly one cycle.
  always_comb begin
    sel_d      = sel_q;
    dir_d      = dir_q;
    tcnt_d     = tcnt_q;
    s_addr_d   = s_addr_q;
    s_be_d     = s_be_q;
    s_wdata_d  = s_wdata_q;
    s_rd_req_d = s_rd_req_q;
    s_wr_req_d = s_wr_req_q;
    rd_ready_d = 1'b0;
    wr_ready_d = 1'b0;
    bus_err_d  = 1'b0;
    rd_data_d  = rd_data_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          dir_d     = bus.wr_req;
          sel_d     = hit_idx;
          s_addr_d  = bus.addr & ~SLV_MASK[int'(hit_idx)*ADDR_LEN +: ADDR_LEN];
          s_be_d    = bus.be;
          s_wdata_d = bus.wr_data;
          tcnt_d    = '0;
          if (hit) begin
            s_wr_req_d = bus.wr_req ? hit_oh : '0;
            s_rd_req_d = bus.wr_req ? '0 : hit_oh;
          end else begin
            rd_ready_d = ~bus.wr_req;
            wr_ready_d = bus.wr_req;
            bus_err_d  = 1'b1;
            rd_data_d  = '0;
            err_cnt_d  = sat_inc(err_cnt_q);
          end
        end
      end
      BUSY: begin
        if (done) begin
          s_rd_req_d = '0;
          s_wr_req_d = '0;
          rd_ready_d = ~dir_q;
          wr_ready_d = dir_q;
          if (!dir_q) rd_data_d = sel_rdata;
        end else if (tmo) begin
          s_rd_req_d = '0;
          s_wr_req_d = '0;
          rd_ready_d = ~dir_q;
          wr_ready_d = dir_q;
          bus_err_d  = 1'b1;
          rd_data_d  = '0;
          err_cnt_d  = sat_inc(err_cnt_q);
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sel_q      <= '0;
      dir_q      <= 1'b0;
      tcnt_q     <= '0;
      s_addr_q   <= '0;
      s_be_q     <= '0;
      s_wdata_q  <= '0;
      s_rd_req_q <= '0;
      s_wr_req_q <= '0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rd_data_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      tcnt_q     <= tcnt_d;
      s_addr_q   <= s_addr_d;
      s_be_q     <= s_be_d;
      s_wdata_q  <= s_wdata_d;
      s_rd_req_q <= s_rd_req_d;
      s_wr_req_q <= s_wr_req_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      bus_err_q  <= bus_err_d;
      rd_data_q  <= rd_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.s_addr    = s_addr_q;
  assign bus.s_be      = s_be_q;
  assign bus.s_wr_data = s_wdata_q;
  assign bus.s_rd_req  = s_rd_req_q;
  assign bus.s_wr_req  = s_wr_req_q;
  assign bus.rd_ready  = rd_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_d_bus_xbar.sv
// Bench for d_bus_xbar: directed vector table, randomized accesses against a
// transaction-level model, and hand sequences for priority, abort and saturation.
module tb_d_bus_xbar;

  localparam int TO = 64;
  localparam logic [15:0] BASE [2] = '{16'h0000, 16'h8000};
  localparam logic [15:0] MASK [2] = '{16'hF000, 16'h8000};

  logic clk;
  logic rstb;

  d_bus_xbar_if #(.XLEN(32), .ADDR_LEN(16), .NUM_SLV(2)) bus_if ();

  d_bus_xbar #(
    .XLEN(32), .ADDR_LEN(16), .NUM_SLV(2),
    .SLV_BASE({16'h8000, 16'h0000}), .SLV_MASK({16'h8000, 16'hF000}),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_errs = 0;
  int          slv_lat [2];
  logic [31:0] slv_data [2];
  bit          stray_rd0 = 1'b0;
  int          scnt [2];
  bit          rdy_v;

  assign bus_if.s_rd_data = {slv_data[1], slv_data[0]};

  // Slave models: ready after slv_lat[i] extra wait cycles (-1 = never answer).
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus_if.s_rd_req[i] | bus_if.s_wr_req[i]) begin
        rdy_v = (slv_lat[i] >= 0) && (scnt[i] == slv_lat[i]);
        scnt[i]++;
      end else begin
        rdy_v = 1'b0;
        scnt[i] = 0;
      end
      bus_if.s_rd_ready[i] = (rdy_v & bus_if.s_rd_req[i]) | ((i == 0) & stray_rd0);
      bus_if.s_wr_ready[i] = rdy_v & bus_if.s_wr_req[i];
    end
  end

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, want 0x%0h", tag, name, act, exp);
    end
  endtask

  // Drives one core access from a negedge and observes it until the ready pulse.
  task automatic access(input bit wr, input logic [15:0] a, input logic [3:0] b, input logic [31:0] wd,
                        output int k, output int sreq, output logic [1:0] vec, output int bad,
                        output logic [15:0] saddr, output logic [3:0] sbe, output logic [31:0] swd,
                        output logic [31:0] rdat, output logic err, output bit pulse_ok);
    logic [1:0] dv, ov;
    bit done;
    k = 0; sreq = 0; vec = 0; bad = 0; saddr = 0; sbe = 0; swd = 0;
    rdat = 0; err = 0; pulse_ok = 0; done = 0;
    bus_if.addr = a; bus_if.be = b; bus_if.wr_data = wd;
    bus_if.wr_req = wr; bus_if.rd_req = !wr;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      dv = wr ? bus_if.s_wr_req : bus_if.s_rd_req;
      ov = wr ? bus_if.s_rd_req : bus_if.s_wr_req;
      if (dv != 0) begin
        if (sreq == 0) begin
          vec = dv; saddr = bus_if.s_addr; sbe = bus_if.s_be; swd = bus_if.s_wr_data;
        end else if (dv != vec) bad++;
        sreq++;
      end
      if (ov != 0) bad++;
      if (bus_if.rd_ready | bus_if.wr_ready) begin
        done = 1; rdat = bus_if.rd_data; err = bus_if.bus_err;
        if (bus_if.rd_ready == wr || bus_if.wr_ready != wr) bad++;
      end
    end
    if (!done) k = -1;
    bus_if.rd_req = 0; bus_if.wr_req = 0;
    @(negedge clk);
    pulse_ok = !(bus_if.rd_ready | bus_if.wr_ready);
  endtask

  // Transaction-level expectation from the address map and slave latencies.
  function automatic void model(input bit wr, input logic [15:0] a,
                                output int k, output int sreq, output logic [1:0] vec,
                                output logic [15:0] saddr, output bit err, output logic [31:0] rdat);
    int hit = -1;
    for (int i = 0; i < 2; i++)
      if (hit < 0 && (a & MASK[i]) == BASE[i]) hit = i;
    saddr = 0; vec = 0; rdat = 0;
    if (hit < 0) begin
      k = 1; sreq = 0; err = 1;
    end else begin
      vec = 2'(1 << hit);
      saddr = a & ~MASK[hit];
      if (slv_lat[hit] >= 0 && slv_lat[hit] < TO) begin
        k = slv_lat[hit] + 2; sreq = slv_lat[hit] + 1; err = 0;
        rdat = wr ? 32'h0 : slv_data[hit];
      end else begin
        k = TO + 1; sreq = TO; err = 1;
      end
    end
  endfunction

  task automatic run_check(input string tag, input bit wr, input logic [15:0] a, input logic [3:0] b,
                           input logic [31:0] wd, input int ek, input int esreq, input logic [1:0] evec,
                           input logic [15:0] esaddr, input bit eerr, input logic [31:0] erd);
    int k, sreq, bad;
    logic [1:0] vec;
    logic [15:0] saddr;
    logic [3:0] sbe;
    logic [31:0] swd, rdat;
    logic err;
    bit pulse_ok;
    access(wr, a, b, wd, k, sreq, vec, bad, saddr, sbe, swd, rdat, err, pulse_ok);
    chk(tag, "latency", k, ek);
    chk(tag, "s_req cycles", sreq, esreq);
    chk(tag, "s_req onehot", {30'b0, vec}, {30'b0, evec});
    chk(tag, "protocol violations", bad, 0);
    chk(tag, "bus_err", {31'b0, err}, {31'b0, eerr});
    if (!wr) chk(tag, "rd_data", rdat, erd);
    if (esreq > 0) chk(tag, "s_addr", {16'b0, saddr}, {16'b0, esaddr});
    if (wr && esreq > 0) begin
      chk(tag, "s_be", {28'b0, sbe}, {28'b0, b});
      chk(tag, "s_wr_data", swd, wd);
    end
    if (eerr) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    chk(tag, "err_cnt", {24'b0, bus_if.err_cnt}, exp_errs);
    chk(tag, "single pulse", {31'b0, pulse_ok}, 32'd1);
  endtask

  typedef struct {
    bit wr; logic [15:0] addr; logic [3:0] be; logic [31:0] wdata;
    int lat0; int lat1; logic [31:0] d0; logic [31:0] d1;
    int ek; int esreq; logic [1:0] evec; logic [15:0] esaddr; bit eerr; logic [31:0] erdat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, sreq, bad, cnt;
    logic [1:0] vec;
    logic [15:0] saddr, ra;
    logic [31:0] rdat;
    logic [3:0] sbe;
    logic [31:0] swd;
    logic err;
    bit pulse_ok, rwr, got, first_wr, saw_rd;
    bit merr;

    vecs[0] = '{wr:0, addr:16'h8010, be:4'hF, wdata:0, lat0:0, lat1:0, d0:0, d1:32'hDEADBEEF,
                ek:2, esreq:1, evec:2'b10, esaddr:16'h0010, eerr:0, erdat:32'hDEADBEEF};
    vecs[1] = '{wr:1, addr:16'h0004, be:4'b0011, wdata:32'h12345678, lat0:5, lat1:0, d0:0, d1:0,
                ek:7, esreq:6, evec:2'b01, esaddr:16'h0004, eerr:0, erdat:0};
    vecs[2] = '{wr:0, addr:16'h4000, be:4'hF, wdata:0, lat0:0, lat1:0, d0:32'h11111111, d1:32'h22222222,
                ek:1, esreq:0, evec:2'b00, esaddr:0, eerr:1, erdat:0};
    vecs[3] = '{wr:0, addr:16'h0FFC, be:4'hF, wdata:0, lat0:2, lat1:0, d0:32'hCAFEF00D, d1:0,
                ek:4, esreq:3, evec:2'b01, esaddr:16'h0FFC, eerr:0, erdat:32'hCAFEF00D};
    vecs[4] = '{wr:0, addr:16'h0100, be:4'hF, wdata:0, lat0:-1, lat1:0, d0:32'h77777777, d1:0,
                ek:65, esreq:64, evec:2'b01, esaddr:16'h0100, eerr:1, erdat:0};
    vecs[5] = '{wr:1, addr:16'hFFFF, be:4'hF, wdata:32'hA1B2C3D4, lat0:0, lat1:1, d0:0, d1:0,
                ek:3, esreq:2, evec:2'b10, esaddr:16'h7FFF, eerr:0, erdat:0};
    vecs[6] = '{wr:0, addr:16'h1000, be:4'hF, wdata:0, lat0:0, lat1:0, d0:32'h33333333, d1:0,
                ek:1, esreq:0, evec:2'b00, esaddr:0, eerr:1, erdat:0};
    vecs[7] = '{wr:0, addr:16'h0008, be:4'hF, wdata:0, lat0:63, lat1:0, d0:32'hA5A5A5A5, d1:0,
                ek:65, esreq:64, evec:2'b01, esaddr:16'h0008, eerr:0, erdat:32'hA5A5A5A5};
    vecs[8] = '{wr:0, addr:16'h8000, be:4'hF, wdata:0, lat0:0, lat1:64, d0:0, d1:32'hFFFFFFFF,
                ek:65, esreq:64, evec:2'b10, esaddr:16'h0000, eerr:1, erdat:0};

    rstb = 0;
    bus_if.addr = 0; bus_if.rd_req = 0; bus_if.wr_req = 0; bus_if.be = 0; bus_if.wr_data = 0;
    slv_lat[0] = 0; slv_lat[1] = 0; slv_data[0] = 0; slv_data[1] = 0;
    repeat (3) @(negedge clk);
    rstb = 1;
    @(negedge clk);
    chk("reset", "rd_ready", {31'b0, bus_if.rd_ready}, 0);
    chk("reset", "wr_ready", {31'b0, bus_if.wr_ready}, 0);
    chk("reset", "bus_err", {31'b0, bus_if.bus_err}, 0);
    chk("reset", "err_cnt", {24'b0, bus_if.err_cnt}, 0);
    chk("reset", "rd_data", bus_if.rd_data, 0);
    chk("reset", "s_req", {28'b0, bus_if.s_rd_req, bus_if.s_wr_req}, 0);
    chk("reset", "s_addr", {16'b0, bus_if.s_addr}, 0);

    for (int i = 0; i < 9; i++) begin
      slv_lat[0] = vecs[i].lat0; slv_lat[1] = vecs[i].lat1;
      slv_data[0] = vecs[i].d0;  slv_data[1] = vecs[i].d1;
      run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                vecs[i].ek, vecs[i].esreq, vecs[i].evec, vecs[i].esaddr, vecs[i].eerr, vecs[i].erdat);
    end

    for (int n = 0; n < 40; n++) begin
      rwr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ra = 16'($urandom_range(0, 16'h0FFF));
        1:       ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        default: ra = 16'($urandom);
      endcase
      for (int i = 0; i < 2; i++) begin
        slv_lat[i]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
        slv_data[i] = $urandom;
      end
      model(rwr, ra, k, sreq, vec, saddr, merr, rdat);
      run_check($sformatf("rand%0d", n), rwr, ra, 4'($urandom), $urandom,
                k, sreq, vec, saddr, merr, rdat);
    end

    // Both requests to slave1: write goes first; a stray slave0 read-ready must be ignored.
    slv_lat[1] = 2; slv_data[1] = 32'h0BADF00D; stray_rd0 = 1;
    bus_if.addr = 16'h8020; bus_if.be = 4'hF; bus_if.wr_data = 32'h11112222;
    bus_if.rd_req = 1; bus_if.wr_req = 1;
    k = 0; got = 0; first_wr = 0; saw_rd = 0;
    while (!got && k < 200) begin
      @(negedge clk); k++;
      if (bus_if.s_rd_req != 0) saw_rd = 1;
      if (bus_if.rd_ready | bus_if.wr_ready) begin got = 1; first_wr = bus_if.wr_ready; end
    end
    chk("both", "write first", {31'b0, first_wr}, 1);
    chk("both", "no read during write", {31'b0, saw_rd}, 0);
    chk("both", "write latency", k, 4);
    bus_if.wr_req = 0;
    k = 0; got = 0; rdat = 0; err = 1;
    while (!got && k < 200) begin
      @(negedge clk); k++;
      if (bus_if.rd_ready) begin got = 1; rdat = bus_if.rd_data; err = bus_if.bus_err; end
    end
    chk("both", "read latency", k, 5);
    chk("both", "read data", rdat, 32'h0BADF00D);
    chk("both", "read bus_err", {31'b0, err}, 0);
    bus_if.rd_req = 0; stray_rd0 = 0;
    @(negedge clk);

    // Core drops its request mid-BUSY; the access still completes.
    slv_lat[0] = 4; slv_data[0] = 32'h600DCAFE;
    bus_if.addr = 16'h0010; bus_if.rd_req = 1;
    k = 0; got = 0; rdat = 0;
    while (!got && k < 200) begin
      @(negedge clk); k++;
      if (k == 2) bus_if.rd_req = 0;
      if (bus_if.rd_ready) begin got = 1; rdat = bus_if.rd_data; end
    end
    chk("drop", "latency", k, 6);
    chk("drop", "rd_data", rdat, 32'h600DCAFE);
    @(negedge clk);

    // Error counter saturation.
    for (int n = 0; n < 260; n++)
      access(0, 16'h4000, 4'hF, 0, k, sreq, vec, bad, saddr, sbe, swd, rdat, err, pulse_ok);
    chk("sat", "err_cnt", {24'b0, bus_if.err_cnt}, 255);

    // Asynchronous reset in the middle of a BUSY access.
    slv_lat[0] = -1;
    bus_if.addr = 16'h0020; bus_if.rd_req = 1;
    repeat (3) @(negedge clk);
    chk("rst", "busy before reset", {30'b0, bus_if.s_rd_req}, 1);
    rstb = 0; bus_if.rd_req = 0;
    #1;
    chk("rst", "s_rd_req", {30'b0, bus_if.s_rd_req}, 0);
    chk("rst", "err_cnt", {24'b0, bus_if.err_cnt}, 0);
    chk("rst", "ready/err", {29'b0, bus_if.rd_ready, bus_if.wr_ready, bus_if.bus_err}, 0);
    chk("rst", "rd_data", bus_if.rd_data, 0);
    chk("rst", "s_addr", {16'b0, bus_if.s_addr}, 0);
    repeat (2) @(negedge clk);
    rstb = 1; exp_errs = 0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.rd_ready | bus_if.wr_ready | (|bus_if.s_rd_req)) cnt++;
    end
    chk("rst", "no activity after reset", cnt, 0);
    slv_lat[1] = 0; slv_data[1] = 32'h12345678;
    run_check("post-reset", 0, 16'h8010, 4'hF, 0, 2, 1, 2'b10, 16'h0010, 0, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
